// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and constants for the router output-port
//                receiver: receive FSM state encoding, default word width and
//                the default word layout held in the receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned NUM_PORTS  = 16;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      IDLE  = 2'd1,
      RECV  = 2'd2,
      FLUSH = 2'd3
   } rx_state_e;

   // Word layout at the default width; the FIFO stores {data, last, err}.
   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic                  last;
      logic                  err;
   } rx_word_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_rx_fifo
//  Description : Synchronous first-word-fall-through FIFO. A write on a full
//                FIFO is ignored (the caller flags the drop); a read on an
//                empty FIFO is ignored. head_o is valid whenever !empty_o.
//  Ports       : clk, reset_n      - clock, synchronous active-low reset
//                push_i/push_data_i - write request and word
//                pop_i              - consume head word
//                full_o/empty_o     - occupancy flags
//                count_o            - entries held (0..DEPTH)
//                head_o             - oldest word
//  Revision    : 1.0 - initial release
// ============================================================================
module router_rx_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [WIDTH-1:0]         head_o
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CNTW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CNTW-1:0]  count_q;
   logic             w_wr;
   logic             w_rd;

   assign full_o  = (count_q == CNTW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Fullness is judged before any same-cycle read, so a pop never makes
   // room for a push in the same cycle.
   assign w_wr = push_i && !full_o;
   assign w_rd = pop_i  && !empty_o;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (w_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({w_wr, w_rd})
            2'b10:   count_q <= count_q + CNTW'(1);
            2'b01:   count_q <= count_q - CNTW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed when non-empty.
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule : router_rx_fifo
`default_nettype wire

// File: rtl/router_port_rx.sv
`default_nettype none
// ============================================================================
//  Module      : router_port_rx
//  Description : Receiver for one router output port. Deserialises the
//                frameo_n/valido_n/dout bit stream LSB-first into DATA_W-bit
//                words, tags each with last/err and queues them in a FWFT
//                FIFO presented as a valid/ready stream.
//  Ports       : clk, reset_n          - clock, synchronous active-low reset
//                frameo_n, valido_n    - router frame / bit-valid, active low
//                dout                  - router serial data
//                rx_data/rx_last/rx_err- FIFO head word and tags
//                rx_valid, rx_ready    - output stream handshake
//                fifo_count            - FIFO entries held
//                overflow, ovf_clr     - sticky drop flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module router_port_rx
   import router_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          frameo_n,
   input  logic                          valido_n,
   input  logic                          dout,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_last,
   output logic                          rx_err,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   localparam int unsigned CW = $clog2(DATA_W + 1);
   localparam int unsigned IW = $clog2(DATA_W);
   localparam int unsigned WW = DATA_W + 2;

   rx_state_e          state_q,      state_d;
   logic [CW-1:0]      bit_cnt_q,    bit_cnt_d;
   logic [DATA_W-1:0]  shift_q,      shift_d;
   logic [DATA_W-1:0]  hold_data_q,  hold_data_d;
   logic               hold_valid_q, hold_valid_d;
   logic               hold_err_q,   hold_err_d;
   logic               overflow_q,   overflow_d;

   logic               w_accept;
   logic               w_end;
   logic               w_word_done;
   logic [DATA_W-1:0]  w_shift_new;
   logic [CW-1:0]      w_cnt_new;
   logic               w_push;
   logic [WW-1:0]      w_push_word;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [WW-1:0]      w_head;
   logic               w_pop;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      hold_err_d   = hold_err_q;
      w_accept     = 1'b0;
      w_end        = 1'b0;
      w_push       = 1'b0;
      w_push_word  = '0;

      case (state_q)
         // Only arm once the line is idle, so a frame already in flight at
         // reset release is ignored entirely.
         SYNC: begin
            if (frameo_n) state_d = IDLE;
         end
         // FLUSH emits the closing word and can also start the next frame.
         IDLE, FLUSH: begin
            if ((state_q == FLUSH) && hold_valid_q) begin
               w_push       = 1'b1;
               w_push_word  = {hold_data_q, 1'b1, hold_err_q};
               hold_valid_d = 1'b0;
               hold_data_d  = '0;
               hold_err_d   = 1'b0;
            end
            if (!frameo_n) begin
               state_d  = RECV;
               w_accept = !valido_n;
            end else begin
               state_d  = IDLE;
            end
         end
         // The final bit arrives together with frameo_n rising.
         RECV: begin
            w_accept = !valido_n;
            if (frameo_n) begin
               w_end   = 1'b1;
               state_d = FLUSH;
            end
         end
         default: state_d = SYNC;
      endcase

      w_shift_new = shift_q;
      if (w_accept) w_shift_new[bit_cnt_q[IW-1:0]] = dout;
      w_cnt_new   = bit_cnt_q + {{(CW-1){1'b0}}, w_accept};
      w_word_done = w_accept && (w_cnt_new == CW'(DATA_W));

      // A finished word (full, or a zero-padded runt at frame end) moves into
      // hold; the previous hold word is then known not to be last.
      if (w_word_done || (w_end && (w_cnt_new != '0))) begin
         if (hold_valid_q) begin
            w_push      = 1'b1;
            w_push_word = {hold_data_q, 1'b0, 1'b0};
         end
         hold_data_d  = w_shift_new;
         hold_valid_d = 1'b1;
         hold_err_d   = !w_word_done;
         shift_d      = '0;
         bit_cnt_d    = '0;
      end else begin
         shift_d      = w_shift_new;
         bit_cnt_d    = w_cnt_new;
      end

      // Setting on a dropped word takes priority over a clear request.
      if (w_push && w_fifo_full) overflow_d = 1'b1;
      else if (ovf_clr)          overflow_d = 1'b0;
      else                       overflow_d = overflow_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= SYNC;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         hold_err_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         hold_err_q   <= hold_err_d;
         overflow_q   <= overflow_d;
      end
   end

   router_rx_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (w_push),
      .push_data_i (w_push_word),
      .pop_i       (w_pop),
      .full_o      (w_fifo_full),
      .empty_o     (w_fifo_empty),
      .count_o     (fifo_count),
      .head_o      (w_head)
   );

   // Head fields are forced to zero while empty so the outputs are defined
   // without resetting FIFO storage.
   assign rx_valid = !w_fifo_empty;
   assign w_pop    = rx_valid && rx_ready;
   assign rx_data  = rx_valid ? w_head[WW-1:2] : '0;
   assign rx_last  = rx_valid && w_head[1];
   assign rx_err   = rx_valid && w_head[0];
   assign overflow = overflow_q;

endmodule : router_port_rx
`default_nettype wire
